cpu_bus_responder: RTL and testbench

- Target-side bus controller for cpu65CE02. Generates the phi1/phi2/phi3 phase strobes and samples the CPU's next-cycle bus outputs (address_next, write_next, data_o_next) at phi2.
- Serves each access from a synchronous RAM port or a handshaked I/O page, then returns read data on data_i in time for the CPU's phi1 sample.
- Inserts wait states by stretching the cycle between phi3 and the next phi1.

---
 rtl/cpu_bus_responder.sv | 188 ++++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// Target-side bus controller for the cpu65CE02: phase strobes, RAM/I-O access, wait-state stretching.
// Optional I/O timeout with bus_error pulse is enabled by defining BUS_TIMEOUT_EN.
//
// state | meaning
// PH1   | phi1 high; CPU samples data_i
// PH2   | phi2 high; CPU next-cycle outputs decoded, RAM port driven
// PH3   | phi3 high; RAM read data captured, first io_ack sample
// WAIT  | no strobe, ready low; RAM wait clocks or waiting for io_ack
`timescale 1ns/1ps
module cpu_bus_responder #(
    parameter logic [7:0]  IO_PAGE    = 8'hD0,
    parameter int unsigned RAM_WAITS  = 0,
    parameter int unsigned IO_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        phi1,
    output logic        phi2,
    output logic        phi3,
    output logic        ready,
    input  logic [15:0] address_next,
    input  logic        write_next,
    input  logic [7:0]  data_o_next,
    output logic [7:0]  data_i,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        io_sel,
    output logic        io_we,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    input  logic        io_ack,
    output logic        bus_error
);

    typedef enum logic [1:0] {PH1, PH2, PH3, WAIT} state_t;

    localparam logic [3:0] RAM_WAITS_M1 = (RAM_WAITS == 0) ? 4'd0 : 4'(RAM_WAITS - 1);

    state_t     state;
    state_t     nxt;
    logic       started;
    logic       cyc_io;
    logic       cyc_we;
    logic [3:0] wait_cnt;
    logic       io_hit;
    logic       io_done;
    logic       io_tmo;
    logic       tmo_hit;

    assign io_hit    = (address_next[15:8] == IO_PAGE);
    assign mem_en    = (state == PH2) && !io_hit;
    assign mem_we    = mem_en && write_next;
    assign mem_addr  = address_next;
    assign mem_wdata = data_o_next;

    always_comb begin
        nxt     = state;
        io_done = 1'b0;
        io_tmo  = 1'b0;
        case (state)
            // the first clock after reset stays in PH1 so phi1 is its first strobe
            PH1: nxt = started ? PH2 : PH1;
            PH2: nxt = PH3;
            PH3: begin
                if (cyc_io) begin
                    if (io_ack) begin
                        nxt     = PH1;
                        io_done = 1'b1;
                    end else begin
                        nxt = WAIT;
                    end
                end else begin
                    nxt = (RAM_WAITS == 0) ? PH1 : WAIT;
                end
            end
            WAIT: begin
                if (cyc_io) begin
                    if (io_ack) begin
                        nxt     = PH1;
                        io_done = 1'b1;
                    end else if (tmo_hit) begin
                        nxt    = PH1;
                        io_tmo = 1'b1;
                    end
                end else if (wait_cnt == 4'd0) begin
                    nxt = PH1;
                end
            end
            default: nxt = PH1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= PH1;
            started  <= 1'b0;
            phi1     <= 1'b0;
            phi2     <= 1'b0;
            phi3     <= 1'b0;
            ready    <= 1'b0;
            data_i   <= 8'h00;
            io_sel   <= 1'b0;
            io_we    <= 1'b0;
            io_addr  <= 8'h00;
            io_wdata <= 8'h00;
            cyc_io   <= 1'b0;
            cyc_we   <= 1'b0;
            wait_cnt <= 4'd0;
        end else begin
            started <= 1'b1;
            state   <= nxt;
            phi1    <= (nxt == PH1);
            phi2    <= (nxt == PH2);
            phi3    <= (nxt == PH3);
            ready   <= (nxt != WAIT);

            if (state == PH2) begin
                cyc_io <= io_hit;
                cyc_we <= write_next;
                if (io_hit) begin
                    io_sel   <= 1'b1;
                    io_we    <= write_next;
                    io_addr  <= address_next[7:0];
                    io_wdata <= data_o_next;
                end
            end

            // WAIT length is wait_cnt+1 clocks, so load one less than the wait count
            if (state == PH3 && !cyc_io) begin
                if (!cyc_we) begin
                    data_i <= mem_rdata;
                end
                wait_cnt <= RAM_WAITS_M1;
            end

            if (state == WAIT && !cyc_io && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (io_done) begin
                if (!cyc_we) begin
                    data_i <= io_rdata;
                end
                io_sel <= 1'b0;
                io_we  <= 1'b0;
            end

            if (io_tmo) begin
                if (!cyc_we) begin
                    data_i <= 8'hFF;
                end
                io_sel <= 1'b0;
                io_we  <= 1'b0;
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(IO_TIMEOUT - 1);

    logic [3:0] tmo_cnt;

    // tmo_cnt holds the number of I/O WAIT clocks already completed
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt   <= 4'd0;
            bus_error <= 1'b0;
        end else begin
            bus_error <= io_tmo;
            if (state == WAIT && cyc_io && tmo_cnt != 4'hF) begin
                tmo_cnt <= tmo_cnt + 4'd1;
            end else if (state != WAIT) begin
                tmo_cnt <= 4'd0;
            end
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder: random RAM / I/O cycles against a transaction-level model.
`timescale 1ns/1ps
module tb_cpu_bus_responder;

    localparam int RW  = 2;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        phi1, phi2, phi3, ready;
    logic [15:0] address_next;
    logic        write_next;
    logic [7:0]  data_o_next;
    logic [7:0]  data_i;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        io_sel, io_we;
    logic [7:0]  io_addr, io_wdata;
    logic [7:0]  io_rdata = 8'h00;
    logic        io_ack = 1'b0;
    logic        bus_error;

    cpu_bus_responder #(.IO_PAGE(8'hD0), .RAM_WAITS(RW), .IO_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .phi1(phi1), .phi2(phi2), .phi3(phi3), .ready(ready),
        .address_next(address_next), .write_next(write_next), .data_o_next(data_o_next),
        .data_i(data_i),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .io_sel(io_sel), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // RAM environment: data appears the clock after mem_en, junk otherwise
    logic [7:0] env_ram [logic [15:0]];
    logic       rd_pend = 1'b0;
    logic [7:0] rd_val  = 8'h00;

    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) env_ram[mem_addr] = mem_wdata;
            else begin
                rd_pend = 1'b1;
                rd_val  = env_ram.exists(mem_addr) ? env_ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_pend) begin
            mem_rdata = rd_val;
            rd_pend   = 1'b0;
        end else begin
            mem_rdata = 8'($urandom);
        end
    end

    // I/O device: acks io_delay clocks after PH3 (0 = ack during PH3)
    logic       resp_en = 1'b0;
    int         io_delay = 0;
    logic [7:0] io_rd_val = 8'h00;
    logic       man_ack = 1'b0;
    logic       io_busy = 1'b0;
    int         io_cnt = 0;

    always @(negedge clk) begin
        io_ack   = 1'b0;
        io_rdata = 8'($urandom);
        if (man_ack) begin
            io_ack   = 1'b1;
            io_rdata = 8'h77;
        end else if (resp_en) begin
            if (phi3 && io_sel) begin
                io_busy = 1'b1;
                io_cnt  = 0;
            end else if (io_busy) begin
                io_cnt++;
            end
            if (io_busy && io_cnt == io_delay) begin
                io_ack   = 1'b1;
                io_rdata = io_rd_val;
                io_busy  = 1'b0;
            end
        end else begin
            io_busy = 1'b0;
        end
    end

    typedef struct {
        logic        is_io;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  data;
        int          len;
        int          err;
    } exp_t;

    exp_t sbq[$];

    // monitor: observes each bus cycle and checks it against the queued expectation at the next phi1
    int          cyc_cnt = 0;
    int          wait_seen = 0;
    int          err_seen = 0;
    logic        o_mem_en = 1'b0, o_mem_we = 1'b0, o_io_sel = 1'b0, o_io_we = 1'b0;
    logic [15:0] o_mem_addr = 16'h0;
    logic [7:0]  o_mem_wdata = 8'h0, o_io_addr = 8'h0, o_io_wdata = 8'h0;

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        ok = ($countones({phi1, phi2, phi3}) <= 1) && (ready == (phi1 | phi2 | phi3)) && (!mem_en || phi2);
        chk("strobe_ready_consistency", 32'(ok), 32'd1);
        if (!phi1 && !phi2 && !phi3) wait_seen++;
        err_seen += int'(bus_error);
        if (phi2) begin
            o_mem_en = mem_en; o_mem_we = mem_we; o_mem_addr = mem_addr; o_mem_wdata = mem_wdata;
        end
        if (phi3) begin
            o_io_sel = io_sel; o_io_we = io_we; o_io_addr = io_addr; o_io_wdata = io_wdata;
        end
        if (phi1) begin
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("cycle_len", 32'(cyc_cnt), 32'(e.len));
                chk("wait_clocks", 32'(wait_seen), 32'(e.len - 3));
                chk("data_i", 32'(data_i), 32'(e.data));
                chk("bus_error_pulses", 32'(err_seen), 32'(e.err));
                chk("io_sel_clear_ph1", 32'(io_sel), 32'd0);
                if (e.is_io) begin
                    chk("io_sel_ph3", 32'(o_io_sel), 32'd1);
                    chk("io_addr", 32'(o_io_addr), 32'(e.addr[7:0]));
                    chk("io_we", 32'(o_io_we), 32'(e.we));
                    chk("io_mem_en_off", 32'(o_mem_en), 32'd0);
                    if (e.we) chk("io_wdata", 32'(o_io_wdata), 32'(e.wdata));
                end else begin
                    chk("mem_en_ph2", 32'(o_mem_en), 32'd1);
                    chk("mem_addr", 32'(o_mem_addr), 32'(e.addr));
                    chk("mem_we", 32'(o_mem_we), 32'(e.we));
                    chk("ram_io_sel_off", 32'(o_io_sel), 32'd0);
                    if (e.we) chk("mem_wdata", 32'(o_mem_wdata), 32'(e.wdata));
                end
            end
            cyc_cnt = 1; wait_seen = 0; err_seen = 0;
            o_mem_en = 1'b0; o_mem_we = 1'b0; o_io_sel = 1'b0; o_io_we = 1'b0;
        end else begin
            cyc_cnt++;
        end
    end

    // reference model: transaction-level RAM contents and last value returned to the CPU
    logic [7:0] model_ram [logic [15:0]];
    logic [7:0] exp_data = 8'h00;

    task automatic wait_phi1();
        int n = 0;
        while (!phi1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("phi1_reached", 32'(phi1), 32'd1);
    endtask

    // dly < 0 means the I/O device never answers
    task automatic do_txn(input logic [15:0] addr, input logic we, input logic [7:0] wd,
                          input int dly, input logic [7:0] rd);
        exp_t e;
        wait_phi1();
        address_next = addr;
        write_next   = we;
        data_o_next  = wd;
        io_delay     = dly;
        io_rd_val    = rd;
        resp_en      = (dly >= 0);
        e.is_io = (addr[15:8] == 8'hD0);
        e.we    = we;
        e.addr  = addr;
        e.wdata = wd;
        e.err   = 0;
        if (e.is_io) begin
            if (dly < 0) begin
                e.len  = 3 + TMO;
                e.data = we ? exp_data : 8'hFF;
                e.err  = 1;
            end else begin
                e.len  = 3 + dly;
                e.data = we ? exp_data : rd;
            end
        end else begin
            e.len = 3 + RW;
            if (we) begin
                model_ram[addr] = wd;
                e.data = exp_data;
            end else begin
                e.data = model_ram.exists(addr) ? model_ram[addr] : init_val(addr);
            end
        end
        exp_data = e.data;
        @(negedge clk);
        sbq.push_back(e);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_ph;
        int n;
        reset        = 1'b1;
        address_next = 16'hD001;
        write_next   = 1'b1;
        data_o_next  = 8'h00;
        resp_en      = 1'b1;
        io_delay     = 0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({phi1, phi2, phi3, ready, data_i, mem_en, mem_we, io_sel, io_we, bus_error}), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_ph = 3'b100 >> (i % 3);
            chk("phi_sequence", 32'({phi1, phi2, phi3}), 32'(exp_ph));
            chk("ready_running", 32'(ready), 32'd1);
        end

        // reset while an I/O read is stalled in WAIT
        wait_phi1();
        address_next = 16'hD033;
        write_next   = 1'b0;
        resp_en      = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!phi3 && n < 20);
        @(negedge clk);
        chk("io_pending_in_wait", 32'({io_sel, ready}), 32'b10);
        @(negedge clk);
        reset        = 1'b1;
        address_next = 16'hD001;
        write_next   = 1'b1;
        resp_en      = 1'b1;
        io_delay     = 0;
        @(negedge clk);
        chk("reset_abandons_io", 32'({io_sel, phi1, phi2, phi3, ready}), 32'd0);
        chk("reset_data_i", 32'(data_i), 32'h00);
        reset = 1'b0;
        @(negedge clk);
        chk("phi1_after_reset", 32'(phi1), 32'd1);
        @(posedge clk); #1 man_ack = 1'b1;
        @(posedge clk); #1 man_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored", 32'(data_i), 32'h00);
        exp_data = 8'h00;

        env_ram[16'h1234]   = 8'hA5;
        model_ram[16'h1234] = 8'hA5;
        do_txn(16'h1234, 1'b0, 8'h00, 0, 8'h00);
        do_txn(16'h0200, 1'b1, 8'h3C, 0, 8'h00);
        do_txn(16'hD020, 1'b0, 8'h00, 4, 8'h5A);
        do_txn(16'hD0FF, 1'b1, 8'h99, 0, 8'h00);
        do_txn(16'h0200, 1'b0, 8'h00, 0, 8'h00);
        do_txn(16'hD010, 1'b0, 8'h00, 0, 8'hC3);

        for (int k = 0; k < 300; k++) begin
            int          sel;
            logic [15:0] a;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0, 1: a = 16'($urandom_range(0, 63));
                2: begin
                    a = 16'($urandom);
                    if (a[15:8] == 8'hD0) a[15:8] = 8'h3E;
                end
                default: a = {8'hD0, 8'($urandom)};
            endcase
            do_txn(a, 1'($urandom), 8'($urandom), int'($urandom_range(0, 6)), 8'($urandom));
        end

`ifdef BUS_TIMEOUT_EN
        do_txn(16'hD044, 1'b0, 8'h00, -1, 8'h00);
        do_txn(16'hD045, 1'b1, 8'h12, -1, 8'h00);
        do_txn(16'h0011, 1'b0, 8'h00, 0, 8'h00);
`endif

        wait_phi1();
        @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
